// File: rtl/wb_ram_slave.sv
// Wishbone B4 classic single-port RAM slave with byte-lane writes, programmable
// wait states and a one-cycle error response for rejected requests.
module wb_ram_slave #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_addr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + (33'd4 << ADDR_WIDTH);
  localparam logic [3:0]  WS    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  state_e                state_q;
  logic [3:0]            cnt_q;
  logic [ADDR_WIDTH-1:0] adr_q;
  logic [31:0]           wdat_q;
  logic [3:0]            sel_q;
  logic                  we_q;
  logic [31:0]           dat_q;
  logic                  ack_q;
  logic                  err_q;
  logic [31:0]           mem [DEPTH];

  logic                  req;
  logic                  bad;
  logic                  acc_go;
  logic                  acc_we;
  logic [ADDR_WIDTH-1:0] acc_adr;
  logic [31:0]           acc_dat;
  logic [3:0]            acc_sel;

  // The access happens either straight from IDLE (no wait states, using the
  // live bus) or on the last WAIT edge (using the latched request).
  always_comb begin
    req     = wb_cyc_i & wb_stb_i;
    bad     = (wb_addr_i[1:0] != 2'b00) || (wb_addr_i < BASE_ADDR) ||
              ({1'b0, wb_addr_i} >= LIMIT) || (wb_sel_i == 4'h0);
    acc_go  = 1'b0;
    acc_we  = we_q;
    acc_adr = adr_q;
    acc_dat = wdat_q;
    acc_sel = sel_q;
    case (state_q)
      ST_IDLE: begin
        acc_go  = req && !bad && (WS == 4'd0);
        acc_we  = wb_we_i;
        acc_adr = wb_addr_i[ADDR_WIDTH+1:2];
        acc_dat = wb_dat_i;
        acc_sel = wb_sel_i;
      end
      ST_WAIT: acc_go = req && (cnt_q == 4'd1);
      default: acc_go = 1'b0;
    endcase
  end

  // Storage is not reset; writes are blocked while reset is held.
  always_ff @(posedge clk_i) begin
    if (!rst_i && acc_go && acc_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (acc_sel[b]) mem[acc_adr][8*b +: 8] <= acc_dat[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      wdat_q  <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      dat_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      if (acc_go) begin
        ack_q <= 1'b1;
        if (!acc_we) dat_q <= mem[acc_adr];
      end
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            if (bad) begin
              err_q   <= 1'b1;
              state_q <= ST_RESP;
            end else begin
              adr_q   <= wb_addr_i[ADDR_WIDTH+1:2];
              wdat_q  <= wb_dat_i;
              sel_q   <= wb_sel_i;
              we_q    <= wb_we_i;
              cnt_q   <= WS;
              state_q <= (WS == 4'd0) ? ST_RESP : ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!req) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == 4'd1) begin
            state_q <= ST_RESP;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign wb_dat_o = dat_q;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;

endmodule
